cdc_clear_seq_sender: RTL and testbench
=======================================

// Module: cdc_clear_seq_sender
// PURPOSE
// Source-side clear-sequence master feeding cdc_4phase_src (data_i/valid_i/ready_o) with
// cdc_reset_ctrlr_pkg::clear_seq_phase_e messages. On a clear request it walks
// ISOLATE -> CLEAR -> POST_CLEAR -> IDLE, sends each phase across the CDC, and drives local
// isolate/clear. It advances only when both the remote echo (return-path cdc_4phase_dst)
// and the local condition of the phase are complete.
// PARAMETERS
// CLEAR_CYCLES  4     min cycles clear_o stays high in CLEAR phase; legal >= 1
// CHECK_ECHO    1'b1  1: echo must equal current phase, mismatch flagged; 0: any echo accepted
// PORTS
// clk_i          in   1  clock
// rst_ni         in   1  reset; synchronous, active-low
// clear_i        in   1  clear request (level or pulse), sampled every cycle
// busy_o         out  1  sequence in progress (state != IDLE)
// done_o         out  1  one-cycle pulse when final IDLE-phase echo completes
// isolate_o      out  1  local isolate request
// isolate_ack_i  in   1  local isolation reached (level)
// clear_o        out  1  local synchronous clear
// phase_o        out  2  clear_seq_phase_e to cdc_4phase_src data_i
// phase_valid_o  out  1  to cdc_4phase_src valid_i
// phase_ready_i  in   1  from cdc_4phase_src ready_o
// echo_phase_i   in   2  clear_seq_phase_e from return cdc_4phase_dst data_o
// echo_valid_i   in   1  from return cdc_4phase_dst valid_o
// echo_ready_o   out  1  to return cdc_4phase_dst ready_i
// echo_err_o     out  1  one-cycle pulse on mismatching echo (CHECK_ECHO=1)
// BEHAVIOUR
// - All outputs registered except echo_ready_o (= state==WAIT).
// - Sync reset: state IDLE, cur_phase=CLEAR_PHASE_IDLE, phase_o=CLEAR_PHASE_IDLE, all 1-bit
//   outputs 0, pending=0, counter=0, flags cleared. Reset mid-sequence aborts immediately,
//   drops isolate_o/clear_o, no done_o.
// - FSM IDLE: clear_i=1 -> cur_phase=ISOLATE, state SEND; phase_valid_o=1 next cycle.
// - SEND: phase_valid_o=1, phase_o=cur_phase held stable until phase_ready_i=1; on that
//   handshake, phase_valid_o=0 next cycle; state WAIT; remote_ok, local_ok cleared.
// - WAIT: echo_ready_o=1. echo_valid_i=1:
//   - echo matches, or CHECK_ECHO=0: consumed; remote_ok=1.
//   - mismatch with CHECK_ECHO=1: consumed; echo_err_o pulse; remote_ok unchanged.
// - local_ok per phase:
//   - ISOLATE: isolate_ack_i=1.
//   - CLEAR: counter reached CLEAR_CYCLES.
//   - POST_CLEAR: isolate_ack_i=0.
//   - IDLE: always 1.
// - Advance: in cycle remote_ok (incl. same-cycle echo) && local_ok, go to SEND with next
//   phase (ISOLATE->CLEAR->POST_CLEAR->IDLE). After IDLE phase completes: state IDLE,
//   done_o=1 for one cycle.
// - isolate_o=1 from SEND(ISOLATE) entry until POST_CLEAR phase is sent (cleared on the
//   POST_CLEAR send handshake).
// - clear_o=1 exactly while cur_phase==CLEAR (SEND and WAIT). Counter: reset on CLEAR
//   entry, +1 per cycle with clear_o=1, saturates at CLEAR_CYCLES (width $clog2(CLEAR_CYCLES+1)).
// - clear_i while busy: sets pending. On completion, pending=1 -> restart to SEND(ISOLATE)
//   the cycle after done_o; pending cleared. Multiple requests merge into one.
// - Echo arriving in SEND or IDLE: echo_ready_o=0; not consumed. Dst holds it (valid/ready).
// - No timeouts; a missing echo stalls in WAIT indefinitely with busy_o=1.
// TESTING
// - Reset, clear_i=0 x10 -> phase_o=IDLE(0), phase_valid_o/busy_o/isolate_o/clear_o/done_o=0.
// - clear_i pulse; ready=1; correct echoes 3 cycles after each send; isolate_ack_i rises 5
//   cycles after isolate_o, falls 2 cycles after POST_CLEAR sent -> phases 1,2,3,0 sent in
//   order; clear_o high >= 4 cycles; one done_o.
// - phase_ready_i held 0 for 7 cycles in SEND(CLEAR) -> phase_o stable at 2, valid held,
//   no advance; clear_o and counter run.
// - CHECK_ECHO=1, echo 2 during ISOLATE wait -> echo_err_o one pulse, stays ISOLATE wait;
//   then echo 1 -> advances.
// - clear_i pulsed during CLEAR phase -> after done_o, new ISOLATE send next cycle;
//   exactly 2 sequences total.
// - rst_ni=0 one cycle during CLEAR wait -> next cycle all outputs at reset values;
//   no done_o; new clear_i restarts from ISOLATE.

Source files
------------

// File: rtl/cdc_clear_seq_sender.sv
// -----------------------------------------------------------------------------
// cdc_clear_seq_sender
// Source-side master for the clear sequence. A clear request walks the phases
// ISOLATE -> CLEAR -> POST_CLEAR -> IDLE. Each phase is sent across the CDC
// through a valid/ready pair into cdc_4phase_src. The phase only advances when
// two things are complete: the far side has echoed the phase back through the
// return cdc_4phase_dst, and the local condition for that phase holds.
//
// Phase encoding (clear_seq_phase_e): 0 IDLE, 1 ISOLATE, 2 CLEAR, 3 POST_CLEAR.
//
// Ports
//   clk_i          clock
//   rst_ni         synchronous active-low reset
//   clear_i        clear request (level or pulse)
//   busy_o         sequence in progress
//   done_o         one-cycle pulse when the final IDLE echo completes
//   isolate_o      local isolate request
//   isolate_ack_i  local isolation reached (level)
//   clear_o        local synchronous clear
//   phase_o        phase to cdc_4phase_src data_i
//   phase_valid_o  to cdc_4phase_src valid_i
//   phase_ready_i  from cdc_4phase_src ready_o
//   echo_phase_i   echoed phase from return cdc_4phase_dst data_o
//   echo_valid_i   from return cdc_4phase_dst valid_o
//   echo_ready_o   to return cdc_4phase_dst ready_i (combinational, = WAIT)
//   echo_err_o     one-cycle pulse on a mismatching echo
// -----------------------------------------------------------------------------
module cdc_clear_seq_sender #(
  parameter int   CLEAR_CYCLES = 4,
  parameter logic CHECK_ECHO   = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       isolate_o,
  input  logic       isolate_ack_i,
  output logic       clear_o,
  output logic [1:0] phase_o,
  output logic       phase_valid_o,
  input  logic       phase_ready_i,
  input  logic [1:0] echo_phase_i,
  input  logic       echo_valid_i,
  output logic       echo_ready_o,
  output logic       echo_err_o
);

  localparam logic [1:0] PH_IDLE    = 2'd0;
  localparam logic [1:0] PH_ISOLATE = 2'd1;
  localparam logic [1:0] PH_CLEAR   = 2'd2;
  localparam logic [1:0] PH_POST    = 2'd3;

  localparam int            CW      = $clog2(CLEAR_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLEAR_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    cur_phase_q, cur_phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pending_q, pending_d;
  logic          remote_ok_q, remote_ok_d;
  logic          isolate_q, isolate_d;
  logic          clear_q, clear_d;
  logic [1:0]    phase_q, phase_d;
  logic          phase_valid_q, phase_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          echo_err_q, echo_err_d;

  logic          echo_take_s;
  logic          echo_ok_s;
  logic          local_ok_s;
  logic [1:0]    next_phase_s;

  // Next-state logic: sequencing FSM, counter, pending request and output images.
  always_comb begin
    state_d     = state_q;
    cur_phase_d = cur_phase_q;
    cnt_d       = cnt_q;
    pending_d   = pending_q;
    remote_ok_d = remote_ok_q;
    isolate_d   = isolate_q;
    done_d      = 1'b0;
    echo_err_d  = 1'b0;

    // An echo is only consumed while waiting; otherwise the dst holds it.
    echo_take_s = (state_q == ST_WAIT) && echo_valid_i;
    echo_ok_s   = echo_take_s && ((echo_phase_i == cur_phase_q) || !CHECK_ECHO);

    case (cur_phase_q)
      PH_ISOLATE: local_ok_s = isolate_ack_i;
      PH_CLEAR:   local_ok_s = (cnt_q == CNT_MAX);
      PH_POST:    local_ok_s = !isolate_ack_i;
      default:    local_ok_s = 1'b1;
    endcase

    case (cur_phase_q)
      PH_ISOLATE: next_phase_s = PH_CLEAR;
      PH_CLEAR:   next_phase_s = PH_POST;
      PH_POST:    next_phase_s = PH_IDLE;
      default:    next_phase_s = PH_IDLE;
    endcase

    // Counter runs while clear_o is high and saturates; CLEAR entry below re-zeroes it.
    if (clear_q && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end

    // Requests arriving mid-sequence collapse into a single restart.
    if (clear_i && (state_q != ST_IDLE)) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (clear_i || pending_q) begin
          state_d     = ST_SEND;
          cur_phase_d = PH_ISOLATE;
          isolate_d   = 1'b1;
          pending_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (phase_ready_i) begin
          state_d     = ST_WAIT;
          remote_ok_d = 1'b0;
          if (cur_phase_q == PH_POST) begin
            isolate_d = 1'b0;
          end else begin
            isolate_d = isolate_q;
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_WAIT: begin
        if (echo_take_s && !echo_ok_s) begin
          echo_err_d = 1'b1;
        end else begin
          echo_err_d = 1'b0;
        end
        if (echo_ok_s) begin
          remote_ok_d = 1'b1;
        end else begin
          remote_ok_d = remote_ok_q;
        end
        // Same-cycle echo counts towards the advance.
        if ((remote_ok_q || echo_ok_s) && local_ok_s) begin
          if (cur_phase_q == PH_IDLE) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d     = ST_SEND;
            cur_phase_d = next_phase_s;
            if (next_phase_s == PH_CLEAR) begin
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q;
            end
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered images of the next state.
    phase_d       = cur_phase_d;
    phase_valid_d = (state_d == ST_SEND);
    busy_d        = (state_d != ST_IDLE);
    clear_d       = (state_d != ST_IDLE) && (cur_phase_d == PH_CLEAR);
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      cur_phase_q   <= PH_IDLE;
      cnt_q         <= '0;
      pending_q     <= 1'b0;
      remote_ok_q   <= 1'b0;
      isolate_q     <= 1'b0;
      clear_q       <= 1'b0;
      phase_q       <= PH_IDLE;
      phase_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      echo_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_phase_q   <= cur_phase_d;
      cnt_q         <= cnt_d;
      pending_q     <= pending_d;
      remote_ok_q   <= remote_ok_d;
      isolate_q     <= isolate_d;
      clear_q       <= clear_d;
      phase_q       <= phase_d;
      phase_valid_q <= phase_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      echo_err_q    <= echo_err_d;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign isolate_o     = isolate_q;
  assign clear_o       = clear_q;
  assign phase_o       = phase_q;
  assign phase_valid_o = phase_valid_q;
  assign echo_err_o    = echo_err_q;
  assign echo_ready_o  = (state_q == ST_WAIT);

endmodule

// File: tb/tb_cdc_clear_seq_sender.sv
// -----------------------------------------------------------------------------
// Bench for cdc_clear_seq_sender. The environment models the far side (echo
// each sent phase after a delay, optionally a wrong echo first) and the local
// isolation logic (ack rises after isolate_o, falls after POST_CLEAR is sent).
// Expectations are transaction level: phase order 1,2,3,0 per sequence,
// sequence/done counts, echo error counts and gating conditions at each send.
// -----------------------------------------------------------------------------
module tb_cdc_clear_seq_sender;
  localparam int CLEAR_CYCLES = 4;

  logic       clk = 1'b0;
  logic       rst_ni, clear_i, isolate_ack_i, phase_ready_i, echo_valid_i;
  logic [1:0] echo_phase_i;
  logic       busy_o, done_o, isolate_o, clear_o, phase_valid_o, echo_ready_o, echo_err_o;
  logic [1:0] phase_o;

  always #5 clk = ~clk;

  cdc_clear_seq_sender #(.CLEAR_CYCLES(CLEAR_CYCLES), .CHECK_ECHO(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .busy_o(busy_o), .done_o(done_o),
    .isolate_o(isolate_o), .isolate_ack_i(isolate_ack_i), .clear_o(clear_o),
    .phase_o(phase_o), .phase_valid_o(phase_valid_o), .phase_ready_i(phase_ready_i),
    .echo_phase_i(echo_phase_i), .echo_valid_i(echo_valid_i), .echo_ready_o(echo_ready_o),
    .echo_err_o(echo_err_o)
  );

  int total = 0;
  int passed = 0;

  logic [1:0] order [4] = '{2'd1, 2'd2, 2'd3, 2'd0};

  // environment state
  int         echo_timer, rise_timer, fall_timer, stall_left, bad_injected;
  logic [1:0] echo_pend_val;
  bit         echo_is_bad, bad_next, rand_mode, stall_on, expect_restart;
  // monitor state
  logic [1:0] sent_q [$];
  int         done_cnt, err_cnt, clear_cnt_seq;
  bit         awaiting_good, iso_prev, done_prev;

  task automatic env_reset();
    clear_i = 1'b0; echo_valid_i = 1'b0; echo_phase_i = 2'd0;
    isolate_ack_i = 1'b0; phase_ready_i = 1'b1;
    echo_timer = 0; rise_timer = 0; fall_timer = 0; stall_left = 0; bad_injected = 0;
    echo_pend_val = 2'd0; echo_is_bad = 1'b0; bad_next = 1'b0; stall_on = 1'b0;
    expect_restart = 1'b0; sent_q.delete(); done_cnt = 0; err_cnt = 0; clear_cnt_seq = 0;
    awaiting_good = 1'b0; iso_prev = 1'b0; done_prev = 1'b0;
  endtask

  task automatic apply_reset();
    rst_ni = 1'b0;
    env_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  // One clock of environment plus monitoring.
  task automatic tick();
    logic       hs_send, hs_echo, ack_pre, iso_pre;
    logic [1:0] ph_pre, exp_ph;
    hs_send = phase_valid_o && phase_ready_i;
    hs_echo = echo_valid_i && echo_ready_o;
    ph_pre  = phase_o;
    ack_pre = isolate_ack_i;
    iso_pre = isolate_o;
    @(posedge clk);
    #1;
    // timers first so events scheduled this tick start counting next tick
    if (echo_timer > 0) begin
      echo_timer--;
      if (echo_timer == 0) begin
        echo_valid_i = 1'b1;
        if (bad_next) begin
          echo_phase_i = echo_pend_val ^ 2'b11;
          echo_is_bad = 1'b1; bad_next = 1'b0; bad_injected++;
        end else begin
          echo_phase_i = echo_pend_val;
        end
      end
    end
    if (rise_timer > 0) begin rise_timer--; if (rise_timer == 0) isolate_ack_i = 1'b1; end
    if (fall_timer > 0) begin fall_timer--; if (fall_timer == 0) isolate_ack_i = 1'b0; end
    if (hs_echo) begin
      echo_valid_i = 1'b0;
      if (echo_is_bad) begin echo_is_bad = 1'b0; echo_timer = 2; end
      else awaiting_good = 1'b0;
    end
    if (hs_send) begin
      exp_ph = order[sent_q.size() % 4];
      total++; if (ph_pre !== exp_ph) $display("FAIL phase_order: got %0d expected %0d", ph_pre, exp_ph); else passed++;
      total++; if (awaiting_good !== 1'b0) $display("FAIL remote_gate: sent %0d before echo, got %0d expected 0", ph_pre, awaiting_good); else passed++;
      total++; if (iso_pre !== (ph_pre != 2'd0)) $display("FAIL isolate_at_send: phase %0d got %0d expected %0d", ph_pre, iso_pre, ph_pre != 2'd0); else passed++;
      if (ph_pre == 2'd1) clear_cnt_seq = 0;
      if (ph_pre == 2'd2) begin
        total++; if (ack_pre !== 1'b1) $display("FAIL isolate_gate: got ack %0d expected 1", ack_pre); else passed++;
      end
      if (ph_pre == 2'd3) begin
        total++; if (clear_cnt_seq < CLEAR_CYCLES) $display("FAIL clear_len: got %0d expected >= %0d", clear_cnt_seq, CLEAR_CYCLES); else passed++;
        total++; if (isolate_o !== 1'b0) $display("FAIL isolate_drop: got %0d expected 0", isolate_o); else passed++;
        fall_timer = rand_mode ? int'($urandom_range(1, 5)) : 2;
      end
      if (ph_pre == 2'd0) begin
        total++; if (ack_pre !== 1'b0) $display("FAIL post_clear_gate: got ack %0d expected 0", ack_pre); else passed++;
      end
      sent_q.push_back(ph_pre);
      awaiting_good = 1'b1;
      echo_pend_val = ph_pre;
      echo_timer = rand_mode ? int'($urandom_range(1, 6)) : 3;
      if (rand_mode && ($urandom_range(0, 3) == 0)) bad_next = 1'b1;
    end
    if (isolate_o && !iso_prev) rise_timer = rand_mode ? int'($urandom_range(1, 8)) : 5;
    // ready: optional stall of the CLEAR send, else ready (random in random mode)
    if (stall_left > 0 && (stall_on || (phase_valid_o && (sent_q.size() % 4 == 1)))) begin
      stall_on = 1'b1;
      total++; if (phase_o !== 2'd2 || phase_valid_o !== 1'b1 || clear_o !== 1'b1)
        $display("FAIL stall_hold: got phase %0d valid %0d clear %0d expected 2 1 1", phase_o, phase_valid_o, clear_o); else passed++;
      phase_ready_i = 1'b0;
      stall_left--;
      if (stall_left == 0) stall_on = 1'b0;
    end else begin
      phase_ready_i = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    if (clear_o) begin
      clear_cnt_seq++;
      total++; if (phase_o !== 2'd2) $display("FAIL clear_phase: got phase %0d expected 2", phase_o); else passed++;
    end
    if (echo_err_o) err_cnt++;
    if (expect_restart && done_prev) begin
      total++; if (phase_valid_o !== 1'b1 || phase_o !== 2'd1) $display("FAIL restart: got valid %0d phase %0d expected 1 1", phase_valid_o, phase_o); else passed++;
      expect_restart = 1'b0;
    end
    if (done_o) begin
      done_cnt++;
      total++; if (done_prev !== 1'b0) $display("FAIL done_width: got prev %0d expected 0", done_prev); else passed++;
      total++; if ({busy_o, isolate_o, clear_o} !== 3'b000) $display("FAIL done_state: got busy/iso/clr %b expected 000", {busy_o, isolate_o, clear_o}); else passed++;
    end
    iso_prev = isolate_o;
    done_prev = done_o;
  endtask

  task automatic pulse_clear();
    clear_i = 1'b1; tick(); clear_i = 1'b0;
  endtask

  task automatic run_until_done(input int n, input int budget);
    for (int i = 0; i < budget && done_cnt < n; i++) tick();
    if (done_cnt < n) begin
      total++; $display("FAIL done_timeout: got %0d done pulses expected %0d", done_cnt, n);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    repeat (10) tick();
    total++; if (phase_o !== 2'd0) $display("FAIL rst_phase: got %0d expected 0", phase_o); else passed++;
    total++; if (phase_valid_o !== 1'b0) $display("FAIL rst_valid: got %0d expected 0", phase_valid_o); else passed++;
    total++; if (busy_o !== 1'b0) $display("FAIL rst_busy: got %0d expected 0", busy_o); else passed++;
    total++; if (isolate_o !== 1'b0) $display("FAIL rst_isolate: got %0d expected 0", isolate_o); else passed++;
    total++; if (clear_o !== 1'b0) $display("FAIL rst_clear: got %0d expected 0", clear_o); else passed++;
    total++; if (done_cnt !== 0) $display("FAIL rst_done: got %0d expected 0", done_cnt); else passed++;
    total++; if (echo_ready_o !== 1'b0) $display("FAIL rst_echo_ready: got %0d expected 0", echo_ready_o); else passed++;
  endtask

  task automatic test_basic();
    apply_reset();
    pulse_clear();
    total++; if (busy_o !== 1'b1) $display("FAIL basic_busy: got %0d expected 1", busy_o); else passed++;
    run_until_done(1, 400);
    repeat (10) tick();
    total++; if (done_cnt !== 1) $display("FAIL basic_done_cnt: got %0d expected 1", done_cnt); else passed++;
    total++; if (sent_q.size() !== 4) $display("FAIL basic_sent_cnt: got %0d expected 4", sent_q.size()); else passed++;
    total++; if (err_cnt !== 0) $display("FAIL basic_err: got %0d expected 0", err_cnt); else passed++;
    total++; if ({busy_o, phase_o, isolate_o, clear_o} !== 5'b0) $display("FAIL basic_idle: got %b expected 00000", {busy_o, phase_o, isolate_o, clear_o}); else passed++;
  endtask

  task automatic test_ready_stall();
    apply_reset();
    stall_left = 7;
    pulse_clear();
    run_until_done(1, 400);
    total++; if (stall_left !== 0) $display("FAIL stall_ran: got %0d left expected 0", stall_left); else passed++;
    total++; if (sent_q.size() !== 4) $display("FAIL stall_sent_cnt: got %0d expected 4", sent_q.size()); else passed++;
    total++; if (clear_cnt_seq < 7) $display("FAIL stall_clear_len: got %0d expected >= 7", clear_cnt_seq); else passed++;
  endtask

  task automatic test_echo_err();
    apply_reset();
    bad_next = 1'b1;
    pulse_clear();
    run_until_done(1, 400);
    repeat (5) tick();
    total++; if (bad_injected !== 1) $display("FAIL err_injected: got %0d expected 1", bad_injected); else passed++;
    total++; if (err_cnt !== 1) $display("FAIL err_pulses: got %0d expected 1", err_cnt); else passed++;
    total++; if (sent_q.size() !== 4) $display("FAIL err_sent_cnt: got %0d expected 4", sent_q.size()); else passed++;
  endtask

  task automatic test_pending();
    int guard;
    apply_reset();
    pulse_clear();
    guard = 0;
    while (!clear_o && guard < 200) begin tick(); guard++; end
    total++; if (clear_o !== 1'b1) $display("FAIL pend_reach_clear: got %0d expected 1", clear_o); else passed++;
    pulse_clear();
    tick();
    pulse_clear();
    expect_restart = 1'b1;
    run_until_done(2, 600);
    repeat (20) tick();
    total++; if (done_cnt !== 2) $display("FAIL pend_done_cnt: got %0d expected 2", done_cnt); else passed++;
    total++; if (sent_q.size() !== 8) $display("FAIL pend_sent_cnt: got %0d expected 8", sent_q.size()); else passed++;
    total++; if (expect_restart !== 1'b0) $display("FAIL pend_restart_seen: got %0d expected 0", expect_restart); else passed++;
    total++; if (busy_o !== 1'b0) $display("FAIL pend_idle: got %0d expected 0", busy_o); else passed++;
  endtask

  task automatic test_reset_mid();
    int guard;
    apply_reset();
    pulse_clear();
    guard = 0;
    while (!(echo_ready_o && phase_o == 2'd2) && guard < 200) begin tick(); guard++; end
    total++; if (clear_o !== 1'b1) $display("FAIL mid_in_clear: got %0d expected 1", clear_o); else passed++;
    rst_ni = 1'b0;
    @(posedge clk);
    #1;
    total++; if ({phase_o, phase_valid_o, busy_o, isolate_o, clear_o, done_o, echo_ready_o, echo_err_o} !== 9'b0)
      $display("FAIL mid_reset_outputs: got %b expected 000000000", {phase_o, phase_valid_o, busy_o, isolate_o, clear_o, done_o, echo_ready_o, echo_err_o}); else passed++;
    rst_ni = 1'b1;
    env_reset();
    repeat (10) tick();
    total++; if (done_cnt !== 0) $display("FAIL mid_no_done: got %0d expected 0", done_cnt); else passed++;
    total++; if (busy_o !== 1'b0) $display("FAIL mid_idle: got %0d expected 0", busy_o); else passed++;
    pulse_clear();
    run_until_done(1, 400);
    total++; if (sent_q.size() !== 4) $display("FAIL mid_restart_sent: got %0d expected 4", sent_q.size()); else passed++;
  endtask

  task automatic test_random();
    apply_reset();
    rand_mode = 1'b1;
    for (int s = 0; s < 5; s++) begin
      pulse_clear();
      run_until_done(s + 1, 800);
      repeat ($urandom_range(1, 5)) tick();
    end
    repeat (10) tick();
    rand_mode = 1'b0;
    total++; if (done_cnt !== 5) $display("FAIL rand_done_cnt: got %0d expected 5", done_cnt); else passed++;
    total++; if (sent_q.size() !== 20) $display("FAIL rand_sent_cnt: got %0d expected 20", sent_q.size()); else passed++;
    total++; if (err_cnt !== bad_injected) $display("FAIL rand_err_cnt: got %0d expected %0d", err_cnt, bad_injected); else passed++;
  endtask

  initial begin
    rand_mode = 1'b0;
    rst_ni = 1'b0;
    env_reset();
    test_reset();
    test_basic();
    test_ready_stall();
    test_echo_err();
    test_pending();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
